// File: rtl/dram_pic_reader.sv
// Fetches one 3-plane picture from DRAM over AXI read (three 64-beat INCR bursts)
// and streams the beats through a 2-entry output FIFO toward the ISP core.
module dram_pic_reader #(
  parameter logic [31:0] BASE_ADDR = 32'h0001_0000,
  parameter logic [3:0]  AXI_ID    = 4'd0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  input  logic [3:0]   req_pic_no,
  output logic         req_ready,
  output logic [3:0]   arid_s_inf,
  output logic [31:0]  araddr_s_inf,
  output logic [7:0]   arlen_s_inf,
  output logic [2:0]   arsize_s_inf,
  output logic [1:0]   arburst_s_inf,
  output logic         arvalid_s_inf,
  input  logic         arready_s_inf,
  input  logic [3:0]   rid_s_inf,
  input  logic [127:0] rdata_s_inf,
  input  logic [1:0]   rresp_s_inf,
  input  logic         rlast_s_inf,
  input  logic         rvalid_s_inf,
  output logic         rready_s_inf,
  output logic         pix_valid,
  input  logic         pix_ready,
  output logic [127:0] pix_data,
  output logic [1:0]   pix_plane,
  output logic         pix_last,
  output logic         rd_err
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DRAIN} state_t;

  state_t       state_q, state_d;
  logic [1:0]   plane_q, plane_d;
  logic [5:0]   beat_q, beat_d;
  logic [3:0]   pic_q, pic_d;
  logic         err_q, err_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [127:0] h_data_q, h_data_d, t_data_q, t_data_d;
  logic [1:0]   h_plane_q, h_plane_d, t_plane_q, t_plane_d;
  logic         h_last_q, h_last_d, t_last_q, t_last_d;
  logic         push, pop, new_last;

  assign arid_s_inf    = AXI_ID;
  assign arlen_s_inf   = 8'd63;
  assign arsize_s_inf  = 3'b100;
  assign arburst_s_inf = 2'b01;
  assign araddr_s_inf  = BASE_ADDR + (32'(pic_q) * 32'hC00) + (32'(plane_q) << 10);

  assign req_ready     = (state_q == IDLE);
  assign arvalid_s_inf = (state_q == ADDR);
  assign rready_s_inf  = (state_q == DATA) && (cnt_q < 2'd2);
  assign push          = rvalid_s_inf && rready_s_inf;
  assign pop           = (cnt_q != 2'd0) && pix_ready;
  assign new_last      = rlast_s_inf && (plane_q == 2'd2);

  assign pix_valid = (cnt_q != 2'd0);
  assign pix_data  = h_data_q;
  assign pix_plane = h_plane_q;
  assign pix_last  = h_last_q && pix_valid;
  assign rd_err    = err_q;

  always_comb begin
    state_d = state_q;
    plane_d = plane_q;
    beat_d  = beat_q;
    pic_d   = pic_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (req_valid) begin
        state_d = ADDR;
        plane_d = 2'd0;
        beat_d  = 6'd0;
        pic_d   = req_pic_no;
        err_d   = 1'b0;
      end
      ADDR: if (arready_s_inf) state_d = DATA;
      DATA: if (push) begin
        beat_d = beat_q + 6'd1;
        if ((rresp_s_inf != 2'b00) || (rid_s_inf != AXI_ID) ||
            (rlast_s_inf && (beat_q != 6'd63)))
          err_d = 1'b1;
        // A short or long burst still terminates on rlast; only the flag records it.
        if (rlast_s_inf) begin
          beat_d = 6'd0;
          if (plane_q == 2'd2) state_d = DRAIN;
          else begin
            plane_d = plane_q + 2'd1;
            state_d = ADDR;
          end
        end
      end
      DRAIN: if (pop && h_last_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    h_data_d  = h_data_q;
    h_plane_d = h_plane_q;
    h_last_d  = h_last_q;
    t_data_d  = t_data_q;
    t_plane_d = t_plane_q;
    t_last_d  = t_last_q;
    if (pop && !push) begin
      h_data_d  = t_data_q;
      h_plane_d = t_plane_q;
      h_last_d  = t_last_q;
      cnt_d     = cnt_q - 2'd1;
    end else if (push && !pop) begin
      if (cnt_q == 2'd0) begin
        h_data_d  = rdata_s_inf;
        h_plane_d = plane_q;
        h_last_d  = new_last;
      end else begin
        t_data_d  = rdata_s_inf;
        t_plane_d = plane_q;
        t_last_d  = new_last;
      end
      cnt_d = cnt_q + 2'd1;
    end else if (push && pop) begin
      if (cnt_q == 2'd1) begin
        h_data_d  = rdata_s_inf;
        h_plane_d = plane_q;
        h_last_d  = new_last;
      end else begin
        h_data_d  = t_data_q;
        h_plane_d = t_plane_q;
        h_last_d  = t_last_q;
        t_data_d  = rdata_s_inf;
        t_plane_d = plane_q;
        t_last_d  = new_last;
      end
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q   <= IDLE;
      plane_q   <= '0;
      beat_q    <= '0;
      pic_q     <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      h_data_q  <= '0;
      h_plane_q <= '0;
      h_last_q  <= 1'b0;
      t_data_q  <= '0;
      t_plane_q <= '0;
      t_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      plane_q   <= plane_d;
      beat_q    <= beat_d;
      pic_q     <= pic_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      h_data_q  <= h_data_d;
      h_plane_q <= h_plane_d;
      h_last_q  <= h_last_d;
      t_data_q  <= t_data_d;
      t_plane_q <= t_plane_d;
      t_last_q  <= t_last_d;
    end
  end

endmodule

// File: doc/dram_pic_reader.md
DRAM_PIC_READER -- requirements
Module: dram_pic_reader

Interface
REQ-001 Parameter BASE_ADDR, 32'h0001_0000, DRAM byte address of picture 0.
REQ-002 Parameter AXI_ID, 4'd0, value driven on arid_s_inf.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; one clock; reset is asynchronous and active-high (rst_n=1 resets).
REQ-005 req_valid  input  1  picture-fetch request.
REQ-006 req_pic_no  input  4  picture index 0-15, sampled on req_valid&&req_ready.
REQ-007 req_ready  output  1  high only in IDLE.
REQ-008 arid_s_inf/araddr_s_inf/arlen_s_inf/arsize_s_inf/arburst_s_inf  output  4/32/8/3/2  AXI read address fields.
REQ-009 arvalid_s_inf  output  1 / arready_s_inf  input  1  AXI read address handshake.
REQ-010 rid_s_inf/rdata_s_inf/rresp_s_inf/rlast_s_inf/rvalid_s_inf  input  4/128/2/1/1  AXI read data.
REQ-011 rready_s_inf  output  1  AXI read data ready.
REQ-012 pix_valid  output  1 / pix_ready  input  1  downstream stream handshake toward ISP core.
REQ-013 pix_data  output  128  16 bytes, byte 0 = bits [7:0].
REQ-014 pix_plane  output  2  colour plane of current beat: 0=R, 1=G, 2=B.
REQ-015 pix_last  output  1  high on final beat (plane 2, beat 63) of the picture.
REQ-016 rd_err  output  1  sticky error flag, cleared by reset or new accepted request.

Function
REQ-017 Picture = 3 planes x 1024 bytes; fetched as three INCR bursts of 64 beats, planes 0,1,2 in order.
REQ-018 Burst k address = BASE_ADDR + pic_no*32'hC00 + k*32'h400; 1 KB-aligned, never crosses 4 KB.
REQ-019 arlen=8'd63, arsize=3'b100, arburst=2'b01, arid=AXI_ID, constant.
REQ-020 FSM states IDLE, ADDR, DATA, DRAIN.
REQ-021 IDLE -> ADDR on req_valid&&req_ready; plane counter=0; rd_err cleared.
REQ-022 ADDR: arvalid=1, araddr stable until arready; arvalid&&arready -> DATA next cycle.
REQ-023 DATA: rready=1 iff output FIFO holds <2 entries; each rvalid&&rready beat pushed with its plane and last tag.
REQ-024 DATA on accepted beat with rlast: plane<2 -> plane+1, ADDR; plane==2 -> DRAIN.
REQ-025 Only one burst outstanding; next AR issued only after previous rlast accepted.
REQ-026 DRAIN -> IDLE in cycle after pix_valid&&pix_ready&&pix_last.
REQ-027 Output FIFO depth 2, registered outputs; pix_valid = FIFO non-empty; pop on pix_valid&&pix_ready; push and pop same cycle when full-and-popping is allowed.
REQ-028 pix_data/pix_plane/pix_last held stable while pix_valid&&!pix_ready.
REQ-029 Beat counter 6 bits; pix_last asserted only for the beat carrying rlast of plane 2.
REQ-030 rd_err set on accepted beat with rresp!=0, rid!=AXI_ID, or rlast at beat count !=63; burst still ends on rlast.
REQ-031 Beats with rlast missing: block waits; no timeout.
REQ-032 Zero-bubble: with pix_ready=1 and back-to-back rvalid, one beat per cycle throughput.

Reset
REQ-033 Reset: state=IDLE, req_ready=1, arvalid=0, rready=0, pix_valid=0, pix_last=0, pix_plane=0, pix_data=0, rd_err=0, FIFO empty, counters 0.
REQ-034 Reset mid-burst abandons transfer immediately; no further AR issued; stale R beats after reset are ignored (rready=0 in IDLE).

Verification
REQ-035 pic_no=0, pix_ready=1, zero-latency DRAM -> AR addresses 0x10000,0x10400,0x10800; 192 pix beats; pix_last only on beat 192; req_ready returns high.
REQ-036 pic_no=15 -> first araddr 0x1B400, last 0x1BC00; arlen 63 each.
REQ-037 pix_ready toggled random 50%, arready delayed 0-5 cycles -> 192 beats in order, data matches DRAM model, no drop/duplicate, outputs stable under stall.
REQ-038 rresp=2'b10 on beat 10 of plane 1 -> rd_err=1 sticky, transfer completes, rd_err cleared on next request.
REQ-039 Reset asserted during plane 1 DATA -> next cycle arvalid=0, pix_valid=0, req_ready=1; new request for pic_no=3 completes correctly.
REQ-040 req_valid held high in DATA -> ignored; second picture starts only after return to IDLE.
